// File: rtl/usbeps_tx_pkg.sv
// Shared widths, descriptor field offsets, FSM state codes and timestamp helpers
// for the USB TX burst scheduler.
package usbeps_tx_pkg;

   localparam int DATA_BITS         = 3;
   localparam int TX_TIMESTAMP_BITS = 49;
   localparam int TX_RAM_ADDR_WIDTH = 17;
   localparam int TX_SAMPLES_WIDTH  = 16;
   localparam int RAM_CHECK_BIT     = 8;
   localparam int FIFO_ADDR_BITS    = 3;
   localparam int FIFO_DEPTH        = 2 ** FIFO_ADDR_BITS;

   localparam int WORD_W            = TX_RAM_ADDR_WIDTH - DATA_BITS;
   localparam int PTR_W             = WORD_W + 1;
   localparam int TS_W              = TX_TIMESTAMP_BITS - 1;
   localparam int CNT_W             = FIFO_ADDR_BITS + 1;
   localparam int OUT_ADDR_W        = TX_RAM_ADDR_WIDTH - RAM_CHECK_BIT + 1;
   localparam int STAT_W            = 48;
   localparam int TX_FE_DESCR_WIDTH = TX_TIMESTAMP_BITS + TX_SAMPLES_WIDTH + WORD_W;

   // Descriptor layout, LSB first: {nots, ts, samples, words_m1}
   localparam int FE_BYTES_OFF      = 0;
   localparam int FE_SAMPLES_OFF    = FE_BYTES_OFF + WORD_W;
   localparam int FE_TS_OFF         = FE_SAMPLES_OFF + TX_SAMPLES_WIDTH;
   localparam int FE_NOTS_OFF       = FE_TS_OFF + TS_W;

   typedef logic [2:0] state_t;
   localparam state_t IDLE  = 3'd0;
   localparam state_t CHECK = 3'd1;
   localparam state_t WAIT  = 3'd2;
   localparam state_t ISSUE = 3'd3;
   localparam state_t PLAY  = 3'd4;
   localparam state_t DROP  = 3'd5;

   function automatic logic ts_due(input logic [TS_W-1:0] diff);
      return diff[TS_W-1] | (diff == {TS_W{1'b0}});
   endfunction

   // One cycle past (diff == -1) still counts as on time.
   function automatic logic ts_late(input logic [TS_W-1:0] diff);
      return diff[TS_W-1] & (diff != {TS_W{1'b1}});
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/usbeps_tx_burst_sched_if.sv
// Descriptor stream (deframer -> scheduler) and read-command/done handshake
// (scheduler <-> fetcher). The master modport is the scheduler's view.
interface usbeps_tx_burst_sched_if;
   import usbeps_tx_pkg::*;

   logic                         s_burst_valid;
   logic                         s_burst_ready;
   logic [TX_FE_DESCR_WIDTH-1:0] s_burst_data;
   logic                         s_burst_busy;
   logic                         rd_cmd_valid;
   logic                         rd_cmd_ready;
   logic [WORD_W-1:0]            rd_cmd_addr;
   logic [WORD_W-1:0]            rd_cmd_words;
   logic [TX_SAMPLES_WIDTH-1:0]  rd_cmd_samples;
   logic                         rd_done;

   modport master (
      input  s_burst_valid, s_burst_data, rd_cmd_ready, rd_done,
      output s_burst_ready, s_burst_busy, rd_cmd_valid, rd_cmd_addr,
             rd_cmd_words, rd_cmd_samples
   );

   modport slave (
      output s_burst_valid, s_burst_data, rd_cmd_ready, rd_done,
      input  s_burst_ready, s_burst_busy, rd_cmd_valid, rd_cmd_addr,
             rd_cmd_words, rd_cmd_samples
   );

endinterface

// File: rtl/usbeps_desc_fifo.sv
// Synchronous first-word-fall-through FIFO for burst descriptors; DEPTH must
// be a power of two. Push when full and pop when empty are ignored.
module usbeps_desc_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      cnt_r;
   logic             push_s;
   logic             pop_s;

   assign push_s = push & ~full;
   assign pop_s  = pop & ~empty;
   assign empty  = (cnt_r == {(AW+1){1'b0}});
   assign full   = (cnt_r == (AW+1)'(DEPTH));
   assign count  = cnt_r;
   assign dout   = mem_r[rd_ptr_r];

   // Descriptor storage; contents need no reset since the count gates reads.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         cnt_r    <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
            2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

endmodule

// File: rtl/usbeps_tx_burst_sched.sv
// Timed playback scheduler: holds queued bursts until their timestamp is due,
// issues one fetch command each and retires them into the TX RAM read pointer.
// Optional feature macro: USBEPS_TX_SCHED_LATE_DROP_EN (drop late bursts).
module usbeps_tx_burst_sched
   import usbeps_tx_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [TS_W-1:0]           cur_time,
   usbeps_tx_burst_sched_if.master   bus,
   output logic [OUT_ADDR_W-1:0]     out_rd_addr,
   output logic [STAT_W-1:0]         stat
);

   state_t                      state_r;
   state_t                      next_state_s;
   logic [TS_W-1:0]             diff_s;
   logic [TS_W-1:0]             diff_r;
   logic [PTR_W-1:0]            rd_ptr_r;
   logic [15:0]                 played_r;
   logic [15:0]                 late_cnt_r;
   logic                        rd_cmd_valid_r;
   logic [WORD_W-1:0]           rd_cmd_addr_r;
   logic [WORD_W-1:0]           rd_cmd_words_r;
   logic [TX_SAMPLES_WIDTH-1:0] rd_cmd_samples_r;
   logic                        busy_r;

   logic [TX_FE_DESCR_WIDTH-1:0] fifo_dout_s;
   logic                         fifo_empty_s;
   logic                         fifo_full_s;
   logic [CNT_W-1:0]             fifo_cnt_s;
   logic [CNT_W-1:0]             cnt_nxt_s;
   logic                         push_s;
   logic                         pop_s;
   logic                         adv_s;
   logic [WORD_W-1:0]            adv_words_s;
   logic                         played_inc_s;
   logic                         late_inc_s;
   logic                         load_cmd_s;

   logic                         head_nots_s;
   logic [TS_W-1:0]              head_ts_s;
   logic [TX_SAMPLES_WIDTH-1:0]  head_samples_s;
   logic [WORD_W-1:0]            head_words_s;

   assign push_s = bus.s_burst_valid & ~fifo_full_s;

   usbeps_desc_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (TX_FE_DESCR_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .din   (bus.s_burst_data),
      .pop   (pop_s),
      .dout  (fifo_dout_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s),
      .count (fifo_cnt_s)
   );

   assign head_words_s   = fifo_dout_s[FE_BYTES_OFF +: WORD_W];
   assign head_samples_s = fifo_dout_s[FE_SAMPLES_OFF +: TX_SAMPLES_WIDTH];
   assign head_ts_s      = fifo_dout_s[FE_TS_OFF +: TS_W];
   assign head_nots_s    = fifo_dout_s[FE_NOTS_OFF];

   // Modular over the timestamp width so a wrapped cur_time reads as "past".
   assign diff_s = head_ts_s - cur_time;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; CHECK decides on the difference captured while in IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s && enable) next_state_s = CHECK;
            else                         next_state_s = IDLE;
         end
         CHECK: begin
            if (head_nots_s)              next_state_s = ISSUE;
`ifdef USBEPS_TX_SCHED_LATE_DROP_EN
            else if (ts_late(diff_r))     next_state_s = DROP;
`endif
            else if (ts_due(diff_r))      next_state_s = ISSUE;
            else                          next_state_s = WAIT;
         end
         WAIT: begin
            if (enable && ts_due(diff_s)) next_state_s = ISSUE;
            else                          next_state_s = WAIT;
         end
         ISSUE: begin
            if (bus.rd_cmd_ready) next_state_s = PLAY;
            else                  next_state_s = ISSUE;
         end
         PLAY: begin
            if (bus.rd_done) next_state_s = IDLE;
            else             next_state_s = PLAY;
         end
`ifdef USBEPS_TX_SCHED_LATE_DROP_EN
         DROP:    next_state_s = IDLE;
`endif
         default: next_state_s = IDLE;
      endcase
   end

   // Per-state datapath controls.
   always_comb begin
      pop_s        = 1'b0;
      adv_s        = 1'b0;
      adv_words_s  = rd_cmd_words_r;
      played_inc_s = 1'b0;
      late_inc_s   = 1'b0;
      load_cmd_s   = (next_state_s == ISSUE) && (state_r != ISSUE);
      case (state_r)
         ISSUE: pop_s = bus.rd_cmd_ready;
         PLAY: begin
            adv_s        = bus.rd_done;
            played_inc_s = bus.rd_done;
         end
`ifdef USBEPS_TX_SCHED_LATE_DROP_EN
         DROP: begin
            pop_s       = 1'b1;
            adv_s       = 1'b1;
            adv_words_s = head_words_s;
            late_inc_s  = 1'b1;
         end
`endif
         default: pop_s = 1'b0;
      endcase
   end

   // Occupancy after this cycle, so busy lines up with the FIFO count.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   cnt_nxt_s = fifo_cnt_s + CNT_W'(1);
         2'b01:   cnt_nxt_s = fifo_cnt_s - CNT_W'(1);
         default: cnt_nxt_s = fifo_cnt_s;
      endcase
   end

   // Command outputs, read pointer, counters and busy flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         diff_r           <= {TS_W{1'b0}};
         rd_ptr_r         <= {PTR_W{1'b0}};
         played_r         <= 16'd0;
         late_cnt_r       <= 16'd0;
         rd_cmd_valid_r   <= 1'b0;
         rd_cmd_addr_r    <= {WORD_W{1'b0}};
         rd_cmd_words_r   <= {WORD_W{1'b0}};
         rd_cmd_samples_r <= {TX_SAMPLES_WIDTH{1'b0}};
         busy_r           <= 1'b0;
      end else begin
         diff_r         <= diff_s;
         rd_cmd_valid_r <= (next_state_s == ISSUE);
         busy_r         <= (cnt_nxt_s >= CNT_W'(FIFO_DEPTH - 1));
         if (load_cmd_s) begin
            rd_cmd_addr_r    <= rd_ptr_r[WORD_W-1:0];
            rd_cmd_words_r   <= head_words_s;
            rd_cmd_samples_r <= head_samples_s;
         end
         if (adv_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(adv_words_s) + PTR_W'(1);
         end
         if (played_inc_s) begin
            played_r <= sat_inc16(played_r);
         end
         if (late_inc_s) begin
            late_cnt_r <= sat_inc16(late_cnt_r);
         end
      end
   end

   assign bus.s_burst_ready  = ~fifo_full_s;
   assign bus.s_burst_busy   = busy_r;
   assign bus.rd_cmd_valid   = rd_cmd_valid_r;
   assign bus.rd_cmd_addr    = rd_cmd_addr_r;
   assign bus.rd_cmd_words   = rd_cmd_words_r;
   assign bus.rd_cmd_samples = rd_cmd_samples_r;

   assign out_rd_addr = rd_ptr_r[PTR_W-1 : RAM_CHECK_BIT-DATA_BITS];
   assign stat        = {late_cnt_r, played_r, {(8-CNT_W){1'b0}}, fifo_cnt_s,
                         5'b00000, state_r};

endmodule

// File: tb/tb_usbeps_tx_burst_sched.sv
// Directed bench for usbeps_tx_burst_sched: latency, timed hold, late handling,
// FIFO full/busy, timestamp wrap, and reset while a burst is in flight.
module tb_usbeps_tx_burst_sched;
   import usbeps_tx_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  enable;
   logic [TS_W-1:0]       cur_time;
   logic [OUT_ADDR_W-1:0] out_rd_addr;
   logic [STAT_W-1:0]     stat;

   int vectors     = 0;
   int miscompares = 0;
   int exp_ptr     = 0;
   int exp_played  = 0;
   int exp_late    = 0;

   usbeps_tx_burst_sched_if bif ();

   usbeps_tx_burst_sched dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .cur_time    (cur_time),
      .bus         (bif.master),
      .out_rd_addr (out_rd_addr),
      .stat        (stat)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [TX_FE_DESCR_WIDTH-1:0] mk(input logic nots, input logic [47:0] ts,
                                                       input logic [15:0] smp, input logic [13:0] wm1);
      return {nots, ts, smp, wm1};
   endfunction

   function automatic logic [47:0] mkstat(input int late, input int played, input int cnt, input state_t st);
      return {16'(late), 16'(played), 8'(cnt), 5'd0, st};
   endfunction

   task automatic push_one(input logic [TX_FE_DESCR_WIDTH-1:0] d);
      bif.s_burst_valid = 1'b1;
      bif.s_burst_data  = d;
      tick();
      bif.s_burst_valid = 1'b0;
   endtask

   task automatic retire();
      bif.rd_cmd_ready = 1'b1;
      tick();
      bif.rd_cmd_ready = 1'b0;
      bif.rd_done      = 1'b1;
      tick();
      bif.rd_done      = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      for (int n = 0; n < 10 && bif.rd_cmd_valid !== 1'b1; n++) tick();
      chk(tag, 64'(bif.rd_cmd_valid), 64'd1);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; cur_time = 48'd0;
      bif.s_burst_valid = 1'b0; bif.s_burst_data = '0;
      bif.rd_cmd_ready = 1'b0; bif.rd_done = 1'b0;
      repeat (3) tick();
      chk("rst_ready", 64'(bif.s_burst_ready), 64'd1);
      chk("rst_busy",  64'(bif.s_burst_busy),  64'd0);
      chk("rst_valid", 64'(bif.rd_cmd_valid),  64'd0);
      chk("rst_stat",  64'(stat),              64'd0);
      chk("rst_addr",  64'(out_rd_addr),       64'd0);
      rst = 1'b0; enable = 1'b1;

      // 1: untimed burst, three-cycle issue latency
      push_one(mk(1'b1, 48'd0, 16'h0007, 14'd15));
      chk("t1_lat1", 64'(bif.rd_cmd_valid), 64'd0);
      tick();
      chk("t1_lat2", 64'(bif.rd_cmd_valid), 64'd0);
      tick();
      chk("t1_valid", 64'(bif.rd_cmd_valid),   64'd1);
      chk("t1_addr",  64'(bif.rd_cmd_addr),    64'd0);
      chk("t1_words", 64'(bif.rd_cmd_words),   64'd15);
      chk("t1_smp",   64'(bif.rd_cmd_samples), 64'h7);
      chk("t1_stat_issue", 64'(stat), 64'(mkstat(0, 0, 1, ISSUE)));
      bif.rd_cmd_ready = 1'b1;
      tick();
      bif.rd_cmd_ready = 1'b0;
      chk("t1_valid_drop", 64'(bif.rd_cmd_valid), 64'd0);
      chk("t1_stat_play", 64'(stat), 64'(mkstat(0, 0, 0, PLAY)));
      bif.rd_done = 1'b1;
      tick();
      bif.rd_done = 1'b0;
      exp_ptr = 16; exp_played = 1;
      chk("t1_stat_idle", 64'(stat), 64'(mkstat(0, 1, 0, IDLE)));
      chk("t1_outaddr", 64'(out_rd_addr), 64'd0);

      // 2: timestamp in the future, held in WAIT until due
      cur_time = 48'd900;
      push_one(mk(1'b0, 48'd1000, 16'h0005, 14'd31));
      tick(); tick();
      chk("t2_wait_valid", 64'(bif.rd_cmd_valid), 64'd0);
      chk("t2_wait_stat", 64'(stat), 64'(mkstat(0, 1, 1, WAIT)));
      cur_time = 48'd998; tick();
      cur_time = 48'd999; tick();
      chk("t2_hold", 64'(bif.rd_cmd_valid), 64'd0);
      cur_time = 48'd1000; tick();
      chk("t2_valid", 64'(bif.rd_cmd_valid), 64'd1);
      chk("t2_addr",  64'(bif.rd_cmd_addr),  64'd16);
      chk("t2_words", 64'(bif.rd_cmd_words), 64'd31);
      retire();
      exp_ptr = 48; exp_played = 2;
      chk("t2_outaddr", 64'(out_rd_addr), 64'd1);

      // 3: late timestamped burst
      cur_time = 48'd500;
      push_one(mk(1'b0, 48'd100, 16'h0009, 14'd7));
      tick(); tick();
`ifdef USBEPS_TX_SCHED_LATE_DROP_EN
      chk("t3_novalid", 64'(bif.rd_cmd_valid), 64'd0);
      chk("t3_stat_drop", 64'(stat), 64'(mkstat(0, 2, 1, DROP)));
      tick();
      exp_late = 1;
`else
      chk("t3_valid", 64'(bif.rd_cmd_valid), 64'd1);
      chk("t3_addr",  64'(bif.rd_cmd_addr),  64'd48);
      chk("t3_words", 64'(bif.rd_cmd_words), 64'd7);
      retire();
      exp_played = 3;
`endif
      exp_ptr = 56;
      chk("t3_stat", 64'(stat), 64'(mkstat(exp_late, exp_played, 0, IDLE)));

      // 4: fill the FIFO with the fetcher stalled, then drain in order
      for (int i = 0; i < 8; i++) begin
         chk("t4_ready_pre", 64'(bif.s_burst_ready), 64'd1);
         push_one(mk(1'b1, 48'd0, 16'(16'h0100 + i), 14'(i)));
         chk("t4_busy", 64'(bif.s_burst_busy), 64'(i >= 6));
      end
      chk("t4_full_ready", 64'(bif.s_burst_ready), 64'd0);
      chk("t4_full_stat", 64'(stat), 64'(mkstat(exp_late, exp_played, 8, ISSUE)));
      bif.s_burst_valid = 1'b1;
      bif.s_burst_data  = mk(1'b1, 48'd0, 16'h01FF, 14'd9);
      tick();
      bif.s_burst_valid = 1'b0;
      chk("t4_held_cnt", 64'(stat[15:8]), 64'd8);
      for (int k = 0; k < 9; k++) begin
         wait_valid("t4_wait_valid");
         chk("t4_words", 64'(bif.rd_cmd_words),   64'(k));
         chk("t4_smp",   64'(bif.rd_cmd_samples), 64'(16'h0100 + k));
         chk("t4_addr",  64'(bif.rd_cmd_addr),    64'(exp_ptr % 16384));
         bif.rd_cmd_ready = 1'b1;
         if (k == 1) begin
            bif.s_burst_valid = 1'b1;
            bif.s_burst_data  = mk(1'b1, 48'd0, 16'h0108, 14'd8);
         end
         tick();
         bif.s_burst_valid = 1'b0;
         bif.rd_cmd_ready  = 1'b0;
         if (k == 1) chk("t4_pushpop_cnt", 64'(stat[15:8]), 64'd7);
         bif.rd_done = 1'b1;
         tick();
         bif.rd_done = 1'b0;
         exp_ptr    = exp_ptr + k + 1;
         exp_played = exp_played + 1;
      end
      chk("t4_outaddr", 64'(out_rd_addr), 64'(exp_ptr >> 5));

      // 5: timestamp just below the wrap, cur_time already wrapped
      cur_time = 48'd3;
      push_one(mk(1'b0, 48'hFFFF_FFFF_FFFE, 16'h0003, 14'd3));
      tick(); tick();
`ifdef USBEPS_TX_SCHED_LATE_DROP_EN
      chk("t5_novalid", 64'(bif.rd_cmd_valid), 64'd0);
      tick();
      exp_late = exp_late + 1;
`else
      chk("t5_valid", 64'(bif.rd_cmd_valid), 64'd1);
      chk("t5_addr",  64'(bif.rd_cmd_addr),  64'(exp_ptr));
      retire();
      exp_played = exp_played + 1;
`endif
      exp_ptr = exp_ptr + 4;
      chk("t5_stat", 64'(stat), 64'(mkstat(exp_late, exp_played, 0, IDLE)));
      chk("t5_outaddr", 64'(out_rd_addr), 64'(exp_ptr >> 5));
      bif.rd_done = 1'b1;
      tick();
      bif.rd_done = 1'b0;
      chk("t5_stray_done_stat", 64'(stat), 64'(mkstat(exp_late, exp_played, 0, IDLE)));

      // 6: reset while a burst is playing
      push_one(mk(1'b1, 48'd0, 16'h0001, 14'd0));
      tick(); tick();
      chk("t6_addr", 64'(bif.rd_cmd_addr), 64'(exp_ptr));
      bif.rd_cmd_ready = 1'b1;
      tick();
      bif.rd_cmd_ready = 1'b0;
      chk("t6_stat_play", 64'(stat), 64'(mkstat(exp_late, exp_played, 0, PLAY)));
      rst = 1'b1;
      tick();
      chk("t6_rst_valid",   64'(bif.rd_cmd_valid), 64'd0);
      chk("t6_rst_outaddr", 64'(out_rd_addr),      64'd0);
      chk("t6_rst_stat",    64'(stat),             64'd0);
      rst = 1'b0;
      bif.rd_done = 1'b1;
      tick();
      bif.rd_done = 1'b0;
      chk("t6_late_done_stat",    64'(stat),              64'd0);
      chk("t6_late_done_outaddr", 64'(out_rd_addr),       64'd0);
      chk("t6_ready",             64'(bif.s_burst_ready), 64'd1);

      // enable low keeps a queued burst parked in IDLE
      enable = 1'b0;
      push_one(mk(1'b1, 48'd0, 16'h0002, 14'd0));
      tick(); tick();
      chk("en_hold_valid", 64'(bif.rd_cmd_valid), 64'd0);
      chk("en_hold_stat", 64'(stat), 64'(mkstat(0, 0, 1, IDLE)));
      enable = 1'b1;
      tick(); tick();
      chk("en_go_valid", 64'(bif.rd_cmd_valid), 64'd1);
      chk("en_go_addr",  64'(bif.rd_cmd_addr),  64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
